// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan arbiter: active-low glyphs {a..g},
// arbiter state encoding and the all-off output patterns.
package ssd_pkg;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;

   localparam logic [7:0] AN_BLANK  = 8'hFF;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic       DP_BLANK  = 1'b1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern, ordered {a..g}.
module ssd_hex_decoder
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/ssd_scan_arbiter.sv
// Two-writer round-robin arbiter feeding a frame-coherent 8-digit multiplexed display.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks digits above the top nonzero nibble.
module ssd_scan_arbiter
   import ssd_pkg::*;
#(
   parameter int SCAN_DIV     = 18,
   parameter int BLANK_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_a,
   input  logic        req_b,
   input  logic [31:0] data_a,
   input  logic [31:0] data_b,
   output logic        gnt_a,
   output logic        gnt_b,
   input  logic [7:0]  digit_en,
   input  logic [7:0]  dp_mask,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        frame_tick
);

   localparam int CNT_W = SCAN_DIV + 3;
   localparam logic [SCAN_DIV-1:0] BLANK_PH = SCAN_DIV'(BLANK_CYCLES);

   arb_state_t         state;
   logic               last_b;
   logic [31:0]        shadow;
   logic [31:0]        active;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         idx;
   logic [SCAN_DIV-1:0] phase;
   logic               wrap;
   logic [3:0]         nibble;
   logic [6:0]         seg_dec;
   logic               lz_blank;
   logic               digit_on;

   assign idx    = cnt[CNT_W-1 -: 3];
   assign phase  = cnt[SCAN_DIV-1:0];
   assign wrap   = &cnt;
   assign nibble = active[{idx, 2'b00} +: 4];

   // Arbiter: a grant always costs one GRANT cycle, so writes are spaced by at least two cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         last_b <= 1'b1;
         gnt_a  <= 1'b0;
         gnt_b  <= 1'b0;
         shadow <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_a && (!req_b || last_b)) begin
                  state  <= ST_GRANT;
                  last_b <= 1'b0;
                  gnt_a  <= 1'b1;
                  gnt_b  <= 1'b0;
                  shadow <= data_a;
               end else if (req_b) begin
                  state  <= ST_GRANT;
                  last_b <= 1'b1;
                  gnt_a  <= 1'b0;
                  gnt_b  <= 1'b1;
                  shadow <= data_b;
               end else begin
                  gnt_a <= 1'b0;
                  gnt_b <= 1'b0;
               end
            end
            ST_GRANT: begin
               state <= ST_IDLE;
               gnt_a <= 1'b0;
               gnt_b <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               gnt_a <= 1'b0;
               gnt_b <= 1'b0;
            end
         endcase
      end
   end

   // Active copy only at the frame boundary; a same-edge grant lands one frame later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         active     <= '0;
         frame_tick <= 1'b0;
      end else begin
         cnt        <= cnt + 1'b1;
         frame_tick <= wrap;
         if (wrap) begin
            active <= shadow;
         end
      end
   end

`ifdef SSD_LEADING_ZERO_BLANK_EN
   logic [2:0] top_digit;

   always_comb begin
      top_digit = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (active[k*4 +: 4] != 4'h0) begin
            top_digit = 3'(k);
         end
      end
   end

   assign lz_blank = (idx > top_digit);
`else
   assign lz_blank = 1'b0;
`endif

   assign digit_on = (phase >= BLANK_PH) && digit_en[idx] && !lz_blank;

   ssd_hex_decoder u_dec (
      .nibble (nibble),
      .seg    (seg_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= AN_BLANK;
         seg <= SEG_BLANK;
         dp  <= DP_BLANK;
      end else if (digit_on) begin
         an  <= ~(8'd1 << idx);
         seg <= seg_dec;
         dp  <= ~dp_mask[idx];
      end else begin
         an  <= AN_BLANK;
         seg <= SEG_BLANK;
         dp  <= DP_BLANK;
      end
   end

endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// Directed bench for ssd_scan_arbiter with SCAN_DIV=4 (16-cycle slots, 128-cycle frames), BLANK_CYCLES=2.
module tb_ssd_scan_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_a, req_b;
   logic [31:0] data_a, data_b;
   logic        gnt_a, gnt_b;
   logic [7:0]  digit_en, dp_mask;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;

   ssd_scan_arbiter #(.SCAN_DIV(4), .BLANK_CYCLES(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_a      (req_a),
      .req_b      (req_b),
      .data_a     (data_a),
      .data_b     (data_b),
      .gnt_a      (gnt_a),
      .gnt_b      (gnt_b),
      .digit_en   (digit_en),
      .dp_mask    (dp_mask),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_tick(input string tag);
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (frame_tick === 1'b1) break;
      end
      check(tag, {31'd0, frame_tick}, 32'd1);
   endtask

   int         bad_an, bad_dp, saw_fe;
   logic [7:0] lit;
   logic [6:0] dseg [8];

   initial begin
      rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
      data_a = '0; data_b = '0; digit_en = 8'hFF; dp_mask = 8'h00;
      step(3);
      check("rst_an",   {24'd0, an},  32'hFF);
      check("rst_seg",  {25'd0, seg}, 32'h7F);
      check("rst_dp",   {31'd0, dp},  32'd1);
      check("rst_gnt_a", {31'd0, gnt_a}, 32'd0);
      check("rst_gnt_b", {31'd0, gnt_b}, 32'd0);
      check("rst_tick", {31'd0, frame_tick}, 32'd0);

      // Release: phases 0 and 1 blank, first anode low one register stage after phase 2.
      rst_n = 1'b1;
      step(1);
      check("blank_ph0", {24'd0, an}, 32'hFF);
      step(1);
      check("blank_ph1", {24'd0, an}, 32'hFF);
      step(1);
      check("first_an", {24'd0, an}, 32'hFE);
      check("first_seg", {25'd0, seg}, 32'h01);
      check("first_dp", {31'd0, dp}, 32'd1);

      // Contention: A first after reset, B two cycles later.
      req_a = 1'b1; req_b = 1'b1;
      data_a = 32'h0000_1234; data_b = 32'hABCD_0000;
      step(1);
      check("cont_gnt_a", {31'd0, gnt_a}, 32'd1);
      check("cont_gnt_b0", {31'd0, gnt_b}, 32'd0);
      req_a = 1'b0;
      step(1);
      check("cont_gap", {30'd0, gnt_a, gnt_b}, 32'd0);
      step(1);
      check("cont_gnt_b", {31'd0, gnt_b}, 32'd1);
      req_b = 1'b0;
      check("cont_shadow", dut.shadow, 32'hABCD_0000);
      step(1);
      check("cont_idle", {30'd0, gnt_a, gnt_b}, 32'd0);

      // Mid-frame write must not disturb the current frame.
      req_a = 1'b1; data_a = 32'h8765_4321;
      step(1);
      check("wr_gnt_a", {31'd0, gnt_a}, 32'd1);
      req_a = 1'b0;
      step(1);
      check("old_frame_an", {24'd0, an}, 32'hFE);
      check("old_frame_seg", {25'd0, seg}, 32'h01);
      wait_tick("tick1");
      step(3);
      check("new_d0_an", {24'd0, an}, 32'hFE);
      check("new_d0_seg", {25'd0, seg}, 32'h4F);
      check("tick_pulse", {31'd0, frame_tick}, 32'd0);
      step(112);
      check("new_d7_an", {24'd0, an}, 32'h7F);
      check("new_d7_seg", {25'd0, seg}, 32'h00);

      // Grant on the wrap edge: active keeps the old shadow for one more frame.
      step(12);
      req_a = 1'b1; data_a = 32'h0000_0002;
      step(1);
      check("same_edge_tick", {31'd0, frame_tick}, 32'd1);
      check("same_edge_gnt", {31'd0, gnt_a}, 32'd1);
      req_a = 1'b0;
      step(3);
      check("same_edge_old", {25'd0, seg}, 32'h4F);
      wait_tick("tick2");
      step(3);
      check("same_edge_new_an", {24'd0, an}, 32'hFE);
      check("same_edge_new", {25'd0, seg}, 32'h12);

      // Masking over one full frame.
      digit_en = 8'h0F; dp_mask = 8'h01;
      bad_an = 0; bad_dp = 0; saw_fe = 0;
      for (int i = 0; i < 128; i++) begin
         step(1);
         if (an[7:4] !== 4'hF) bad_an++;
         if ((dp === 1'b0) !== (an === 8'hFE)) bad_dp++;
         if (an === 8'hFE) saw_fe++;
      end
      check("mask_an_hi", bad_an, 32'd0);
      check("mask_dp", bad_dp, 32'd0);
      check("mask_d0_cycles", saw_fe, 32'd14);

      // Leading zeros with active = 0000_00A0.
      digit_en = 8'hFF; dp_mask = 8'h00;
      req_b = 1'b1; data_b = 32'h0000_00A0;
      step(1);
      check("lz_gnt_b", {31'd0, gnt_b}, 32'd1);
      req_b = 1'b0;
      wait_tick("tick3");
      lit = 8'h00;
      for (int k = 0; k < 8; k++) dseg[k] = 7'h7F;
      for (int i = 0; i < 128; i++) begin
         step(1);
         for (int k = 0; k < 8; k++) begin
            if (an === ~(8'd1 << k)) begin
               lit[k] = 1'b1;
               dseg[k] = seg;
            end
         end
      end
`ifdef SSD_LEADING_ZERO_BLANK_EN
      check("lz_lit", {24'd0, lit}, 32'h03);
      check("lz_d0", {25'd0, dseg[0]}, 32'h01);
      check("lz_d1", {25'd0, dseg[1]}, 32'h08);
`else
      check("lz_lit", {24'd0, lit}, 32'hFF);
      check("lz_d0", {25'd0, dseg[0]}, 32'h01);
      check("lz_d1", {25'd0, dseg[1]}, 32'h08);
      check("lz_d2", {25'd0, dseg[2]}, 32'h01);
      check("lz_d7", {25'd0, dseg[7]}, 32'h01);
`endif

      // Reset in the grant cycle drops gnt at once and leaves the buffers cleared.
      req_a = 1'b1; data_a = 32'hFFFF_FFFF;
      step(1);
      check("mg_gnt_a", {31'd0, gnt_a}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mg_gnt_drop", {31'd0, gnt_a}, 32'd0);
      check("mg_an", {24'd0, an}, 32'hFF);
      req_a = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(2);
      check("mg_blank", {24'd0, an}, 32'hFF);
      step(1);
      check("mg_d0_an", {24'd0, an}, 32'hFE);
      check("mg_d0_seg", {25'd0, seg}, 32'h01);
      wait_tick("tick4");
      step(3);
      check("mg_shadow_an", {24'd0, an}, 32'hFE);
      check("mg_shadow_seg", {25'd0, seg}, 32'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssd_scan_arbiter.md
SSD_SCAN_ARBITER -- requirements
Module: ssd_scan_arbiter

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 18: each digit is lit for 2^SCAN_DIV clk cycles (2.62 ms at 100 MHz).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 64: all anodes are off for this many cycles at the start of each digit slot; legal range 0 to 2^SCAN_DIV-1.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; the block uses this single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports req_a / req_b, inputs, 1 bit each: write requests; req_a is the game score, req_b is the debug value.
REQ-006 The block SHALL have ports data_a / data_b, inputs, 32 bits each: eight hex nibbles; nibble k drives digit k.
REQ-007 The block SHALL have ports gnt_a / gnt_b, outputs, 1 bit each: one-cycle grant pulses.
REQ-008 The block SHALL have port digit_en, input, 8 bits: per-digit enable; 0 blanks that digit.
REQ-009 The block SHALL have port dp_mask, input, 8 bits: 1 lights that digit's decimal point.
REQ-010 The block SHALL have port an, output, 8 bits: active-low anodes.
REQ-011 The block SHALL have port seg, output, 7 bits: active-low segments, ordered {a..g}.
REQ-012 The block SHALL have port dp, output, 1 bit: active-low decimal point.
REQ-013 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse when the digit index wraps from 7 to 0.

Function
REQ-014 The arbiter FSM SHALL have two states, IDLE and GRANT.
- IDLE with any request: move to GRANT, pulse the winner's gnt, and latch the winner's data into the shadow register on the same edge.
- GRANT: always return to IDLE; no grant is issued while in GRANT.
REQ-015 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; after reset, A wins first.
REQ-016 A requester SHALL hold req and data stable until it sees gnt; a req still high in the cycle after the gnt pulse SHALL count as a new request.
REQ-017 Write throughput SHALL be at most one write per 2 cycles; grant latency from req sampled in IDLE SHALL be 1 cycle.
REQ-018 The scan counter SHALL be SCAN_DIV+3 bits wide and SHALL wrap freely.
- Upper 3 bits are the digit index (0..7).
- Lower SCAN_DIV bits are the slot phase.
REQ-019 The shadow register SHALL copy into the active register only on the cycle the digit index wraps 7->0 (frame_tick cycle), so that no frame shows a mix of old and new data.
REQ-020 If a grant and a frame wrap happen on the same edge, the active register SHALL take the old shadow value; the new data appears on the following frame.
REQ-021 When slot phase < BLANK_CYCLES or digit_en[idx]==0, an SHALL be 8'hFF, seg 7'h7F and dp 1; otherwise an SHALL be ~(1<<idx), seg the decoded nibble and dp ~dp_mask[idx].
REQ-022 an, seg and dp SHALL be registered (1-cycle latency from counter to pins), glitch-free, and never more than one anode low at a time.

Reset
REQ-023 While rst_n is low, the block SHALL hold: an=8'hFF, seg=7'h7F, dp=1, gnt_a=gnt_b=0, frame_tick=0, FSM=IDLE, last-granted=B, scan counter=0, shadow and active registers=0.
REQ-024 Reset asserted mid-grant SHALL drop the gnt pulse immediately with no buffer update; after release, scanning SHALL resume at digit 0 with blanking.

Configuration
REQ-025 With SSD_LEADING_ZERO_BLANK_EN defined, the block SHALL also blank every digit above the highest nonzero nibble of the active register; digit 0 is never blanked by this rule.
REQ-026 Without SSD_LEADING_ZERO_BLANK_EN, every enabled digit SHALL display, zeros included.

Structure
REQ-027 Package ssd_pkg SHALL hold the 16 active-low segment constants (0-F), the FSM state encoding and the blank-pattern constants.
REQ-028 Sub-module ssd_hex_decoder SHALL be combinational: 4-bit nibble in, 7-bit active-low segments out.

Verification (SCAN_DIV=4, BLANK_CYCLES=2)
REQ-029 Reset scenario: hold rst_n low, then release -> outputs at reset values; first anode low is an=8'hFE, 2 cycles after the first slot start.
REQ-030 Contention scenario: req_a and req_b high together with data_a=32'h0000_1234, data_b=32'hABCD_0000 -> gnt_a first; gnt_b 2 cycles later; final shadow=32'hABCD_0000.
REQ-031 Frame coherency scenario: write 32'h8765_4321 mid-frame -> current frame unchanged; after the next frame_tick, digit 0 shows seg=7'b1001111 ("1") and digit 7 shows seg=7'b0000000 ("8").
REQ-032 Masking scenario: digit_en=8'h0F, dp_mask=8'h01 -> an[7:4] never low; dp=0 only while an=8'hFE.
REQ-033 Leading-zero scenario: active register 32'h0000_00A0, macro defined -> only digits 0 and 1 are lit; without the macro, all 8 digits are lit and digits 2..7 show "0".
REQ-034 Mid-grant reset scenario: pull rst_n low in the cycle gnt_a is high -> gnt_a=0 immediately; shadow=0 after release.
